// File: rtl/mult_pkg.sv
// Shared widths and types for the 32x32 -> 64 unsigned array multiplier.
package mult_pkg;
    localparam int MULT_W = 32;
    localparam int PROD_W = 64;
    typedef logic [MULT_W-1:0] operand_t;
    typedef logic [PROD_W-1:0] product_t;
endpackage

// File: rtl/csa_3to2.sv
// Full-width 3:2 carry-save adder; carry is pre-shifted to its weight.
module csa_3to2
    import mult_pkg::*;
(
    input  product_t x,
    input  product_t y,
    input  product_t z,
    output product_t sum,
    output product_t carry
);
    product_t maj_s;

    assign sum   = x ^ y ^ z;
    assign maj_s = (x & y) | (x & z) | (y & z);
    // The top majority bit is dropped: the exact product never exceeds 64 bits.
    assign carry = {maj_s[PROD_W-2:0], 1'b0};
endmodule

// File: rtl/parallel_multiplier.sv
// Unsigned 32x32 -> 64 array multiplier: partial products, carry-save chain, final adder.
// Define MULT_PIPE_EN to register r/valid_out (1-cycle latency); otherwise fully combinational.
module parallel_multiplier
    import mult_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     valid_in,
    input  operand_t a,
    input  operand_t b,
    output product_t r,
    output logic     valid_out
);
    product_t pp_s    [MULT_W];
    product_t sum_s   [MULT_W-2];
    product_t carry_s [MULT_W-2];
    product_t prod_s;

    // Partial-product rows: row i is a shifted by i when b[i] is set.
    always_comb begin
        for (int i = 0; i < MULT_W; i++) begin
            if (b[i]) begin
                pp_s[i] = product_t'(a) << i;
            end else begin
                pp_s[i] = '0;
            end
        end
    end

    // Each stage folds one more row into the running sum/carry pair.
    genvar k;
    generate
        for (k = 0; k < MULT_W - 2; k++) begin : g_tree
            if (k == 0) begin : g_first
                csa_3to2 u_csa (
                    .x     (pp_s[0]),
                    .y     (pp_s[1]),
                    .z     (pp_s[2]),
                    .sum   (sum_s[0]),
                    .carry (carry_s[0])
                );
            end else begin : g_next
                csa_3to2 u_csa (
                    .x     (sum_s[k-1]),
                    .y     (carry_s[k-1]),
                    .z     (pp_s[k+2]),
                    .sum   (sum_s[k]),
                    .carry (carry_s[k])
                );
            end
        end
    endgenerate

    assign prod_s = sum_s[MULT_W-3] + carry_s[MULT_W-3];

`ifdef MULT_PIPE_EN
    product_t r_r;
    logic     valid_out_r;

    // Output register stage; reset discards any in-flight operand pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_r         <= '0;
            valid_out_r <= 1'b0;
        end else begin
            r_r         <= prod_s;
            valid_out_r <= valid_in;
        end
    end

    assign r         = r_r;
    assign valid_out = valid_out_r;
`else
    assign r         = prod_s;
    assign valid_out = valid_in & ~reset;
`endif
endmodule

// File: tb/tb_parallel_multiplier.sv
// Self-checking bench for parallel_multiplier in either build (MULT_PIPE_EN or not).
module tb_parallel_multiplier;
    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    logic        valid_out;

    int total;
    int bad;

    logic        chk_en;
    logic        pin_en;
    logic [63:0] pin_r;
    logic        pin_v;

    logic [63:0] m_r;
    logic        m_v;

    parallel_multiplier dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .a         (a),
        .b         (b),
        .r         (r),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] wx;
        logic [63:0] wy;
        wx = {32'h0, x};
        wy = {32'h0, y};
        return wx * wy;
    endfunction

    // Reference for the registered build: what the output stage must hold after each edge.
    always @(posedge clk) begin
        if (reset) begin
            m_r <= 64'h0;
            m_v <= 1'b0;
        end else begin
            m_r <= ref_prod(a, b);
            m_v <= valid_in;
        end
    end

    // Compare process: checks DUT outputs against the model every falling edge.
    always @(negedge clk) begin
        logic [63:0] exp_r;
        logic        exp_v;
`ifdef MULT_PIPE_EN
        exp_r = m_r;
        exp_v = m_v;
`else
        exp_r = ref_prod(a, b);
        exp_v = valid_in & ~reset;
`endif
        if (chk_en) begin
            total = total + 1;
            if (r !== exp_r) begin
                bad = bad + 1;
                $display("FAIL prod a=%h b=%h r=%h expected=%h", a, b, r, exp_r);
            end
            total = total + 1;
            if (valid_out !== exp_v) begin
                bad = bad + 1;
                $display("FAIL valid valid_out=%b expected=%b", valid_out, exp_v);
            end
            if (pin_en) begin
                total = total + 1;
                if (r !== pin_r || valid_out !== pin_v) begin
                    bad = bad + 1;
                    $display("FAIL pin r=%h v=%b expected r=%h v=%b", r, valid_out, pin_r, pin_v);
                end
            end
        end
    end

    // Drive one operand set (called just after a rising edge) and pin the literal result.
    task automatic run(input logic [31:0] ta, input logic [31:0] tb_, input logic tv,
                       input logic trst, input logic [63:0] er, input logic ev);
        a        = ta;
        b        = tb_;
        valid_in = tv;
        reset    = trst;
        pin_r    = er;
        pin_v    = ev;
`ifdef MULT_PIPE_EN
        @(negedge clk);
        #1;
`endif
        pin_en = 1'b1;
        @(negedge clk);
        #1;
        pin_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        chk_en   = 1'b0;
        pin_en   = 1'b0;
        pin_r    = 64'h0;
        pin_v    = 1'b0;
        reset    = 1'b1;
        valid_in = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset state, then hand-computed products.
        run(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 64'h0, 1'b0);
        run(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 64'h0, 1'b1);
        run(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 64'd15, 1'b1);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        run(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 64'h0000_0001_0000_0000, 1'b1);
        run(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h0, 1'b1);
        run(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1);
        run(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 1'b1);

        // valid_in toggling 1,0,1 with fixed operands.
        run(32'h0000_1234, 32'h0000_0010, 1'b1, 1'b0, 64'h0000_0000_0001_2340, 1'b1);
        run(32'h0000_1234, 32'h0000_0010, 1'b0, 1'b0, 64'h0000_0000_0001_2340, 1'b0);
        run(32'h0000_1234, 32'h0000_0010, 1'b1, 1'b0, 64'h0000_0000_0001_2340, 1'b1);

        // Reset asserted together with a valid operand pair, then released.
`ifdef MULT_PIPE_EN
        run(32'h0000_0007, 32'h0000_0009, 1'b1, 1'b1, 64'h0, 1'b0);
`else
        run(32'h0000_0007, 32'h0000_0009, 1'b1, 1'b1, 64'd63, 1'b0);
`endif
        run(32'h0000_0007, 32'h0000_0009, 1'b1, 1'b0, 64'd63, 1'b1);

        // Arithmetic sweep: fixed increments each cycle, checked by the compare process.
        a        = 32'h0;
        b        = 32'h0;
        valid_in = 1'b1;
        reset    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            a = a + 32'h2345_6789;
            b = b + 32'h3456_7891;
        end

        // Random operands with walking-one and all-ones patterns mixed in.
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            a        = $urandom;
            b        = $urandom;
            valid_in = 1'($urandom_range(0, 1));
            case (i % 8)
                0:       a = 32'h1 << (i % 32);
                1:       b = 32'h1 << ((i / 8) % 32);
                2:       a = 32'hFFFF_FFFF;
                3:       b = 32'h0;
                default: ;
            endcase
        end

        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parallel_multiplier.md
# parallel_multiplier

Unsigned 32×32→64-bit parallel array multiplier for datapath arithmetic that needs a full-width product in the same cycle. The product is formed from 32 partial-product rows reduced by a carry-save tree and one final carry-propagate adder. A valid flag travels alongside the data. An optional output register stage trades one cycle of latency for timing.

## Interface
Parameters:
- none. Widths are fixed: 32-bit operands, 64-bit product.

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  marks a and b as carrying a valid operand pair.
- a  input  32  unsigned multiplicand.
- b  input  32  unsigned multiplier.
- r  output  64  unsigned product a*b.
- valid_out  output  1  marks r as valid.

## Operation
- Arithmetic:
  - r = a * b, unsigned, exact 64-bit result with no truncation or overflow.
  - The RTL must not use the `*` operator.
- Partial products: pp[i] = b[i] ? (a << i) : 0, for i = 0..31.
- Reduction:
  - Rows are compressed with 3:2 carry-save adders until two 64-bit vectors remain.
  - A 64-bit ripple or prefix adder then produces r.
- valid_in does not gate the arithmetic; r always reflects the current (or registered) a and b.
- Default build (combinational):
  - r is purely combinational from a and b.
  - valid_out = valid_in & ~reset.
  - reset has no effect on r.

## Timing
- Default build:
  - Zero-cycle latency.
  - r is settled within the same clock period that a and b change.
  - The product of operands applied after edge N must be correct when sampled at edge N+1.
- With MULT_PIPE_EN:
  - Latency is 1 cycle. Operands sampled at edge N appear on r, with valid_out = valid_in, after edge N.
  - New operands are accepted every cycle (throughput 1/cycle).
- Reset (pipelined build):
  - At a clock edge with reset=1, r <= 0 and valid_out <= 0. Any in-flight operand is discarded.
  - In the first cycle after reset deasserts, r shows the product sampled at that edge.
- Reset (default build): valid_out is 0 while reset is high. r follows a*b.
- Boundary operands must be exact: 0 on either side, all-ones on both sides, single-bit operands.

## Configuration
- MULT_PIPE_EN:
  - Defined: r and valid_out are registered (1-cycle latency). reset clears both registers.
  - Undefined: fully combinational product; no data registers are inferred.

## Structure
- Shared package mult_pkg holds:
  - localparam MULT_W = 32;
  - localparam PROD_W = 64;
  - typedef logic [MULT_W-1:0] operand_t;
  - typedef logic [PROD_W-1:0] product_t.
- One sub-module, csa_3to2: a PROD_W-wide carry-save adder producing sum and carry (carry shifted left by 1). It is instantiated across the reduction tree via a generate loop.
- The top module holds partial-product generation, the tree, the final adder, and the optional output register.

## Test plan
- a=0, b=0 → r=64'h0. Then a=3, b=5 → r=15.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF → r=64'hFFFFFFFE00000001. Also a=32'h00010000, b=32'h00010000 → r=64'h0000000100000000.
- Sweep: start a=0, b=0. Each cycle add 32'h23456789 to a and 32'h34567891 to b (wrapping mod 2^32). For 100 cycles, check at each posedge that r equals the 64-bit reference product; any mismatch is fatal.
- valid_in toggled 1,0,1 with fixed operands:
  - default build: valid_out mirrors valid_in in the same cycle;
  - MULT_PIPE_EN: valid_out mirrors valid_in one cycle later.
- MULT_PIPE_EN only: apply a=7, b=9 with valid_in=1 and assert reset at the same edge → r=0 and valid_out=0 after that edge. Deassert reset → r=63 and valid_out=1 after the next edge.
- Random: 10,000 random a,b pairs, including walking-one operands → r matches the reference product in both builds, with latency checked as above.
